// File: rtl/fir_coeff_loader.sv
// fir_coeff_loader
//   Front end of the 4-way interleaved FIR. It accepts a coefficient stream on a
//   valid/ready handshake and replays it as the coefficient-update write sequence
//   the FIR controller consumes. The stream is N coefficients followed by one
//   checksum word (the modulo-2^DATA_WIDTH sum of the coefficients). The tap count
//   is committed only when the checksum matches.
//
// Ports
//   iClk12M, iRst     clock, asynchronous active-high reset
//   iStart, iNumReq   load request and requested tap count (sampled together)
//   iCoeffValid/Data  stream word in; oCoeffReady is the accept side of the handshake
//   oCoeffUpdateFlag  high while coefficients are being written
//   oWrStrobe         one-cycle qualifier for oAddrRam / oWrDtRam
//   oNumOfCoeff       committed tap count
//   oBusy, oDone      load in progress, one-cycle end-of-attempt pulse
//   oErr              0 ok, 1 bad count, 2 checksum mismatch, 3 timeout
module fir_coeff_loader #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 6,
   parameter int MAX_COEFF  = 40,
   parameter int TIMEOUT    = 4095
) (
   input  logic                  iClk12M,
   input  logic                  iRst,
   input  logic                  iStart,
   input  logic [ADDR_WIDTH-1:0] iNumReq,
   input  logic                  iCoeffValid,
   input  logic [DATA_WIDTH-1:0] iCoeffData,
   output logic                  oCoeffReady,
   output logic                  oCoeffUpdateFlag,
   output logic                  oWrStrobe,
   output logic [ADDR_WIDTH-1:0] oAddrRam,
   output logic [DATA_WIDTH-1:0] oWrDtRam,
   output logic [ADDR_WIDTH-1:0] oNumOfCoeff,
   output logic                  oBusy,
   output logic                  oDone,
   output logic [1:0]            oErr
);

   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CHECK, S_DONE} state_t;

   state_t                state, state_nxt;
   logic [ADDR_WIDTH-1:0] n_req;
   logic [ADDR_WIDTH-1:0] idx;
   logic [DATA_WIDTH-1:0] sum;
   logic [TW-1:0]         timer;
   logic                  accept;
   logic                  start_ok;
   logic                  last_word;
   logic                  expired;

   assign accept    = iCoeffValid && oCoeffReady;
   assign start_ok  = (iNumReq != '0) && (32'(iNumReq) <= MAX_COEFF);
   assign last_word = (idx == ADDR_WIDTH'(n_req - 1'b1));
   // timer holds the number of idle cycles already seen, so this is the
   // TIMEOUT-th consecutive idle cycle; an acceptance always overrides it.
   assign expired   = !accept && (timer == TW'(TIMEOUT - 1));

   assign oCoeffReady      = (state == S_LOAD) || (state == S_CHECK);
   assign oBusy            = oCoeffReady;
   assign oDone            = (state == S_DONE);
   // The last coefficient strobes in the first CHECK cycle; keep the flag
   // up so the controller sees every write inside its update window.
   assign oCoeffUpdateFlag = (state == S_LOAD) || oWrStrobe;

   always_ff @(posedge iClk12M or posedge iRst) begin
      if (iRst) state <= S_IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (iStart) state_nxt = start_ok ? S_LOAD : S_DONE;
         S_LOAD: begin
            if (accept && last_word) state_nxt = S_CHECK;
            else if (expired)        state_nxt = S_DONE;
         end
         S_CHECK: if (accept || expired) state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge iClk12M or posedge iRst) begin
      if (iRst) begin
         n_req       <= '0;
         idx         <= '0;
         sum         <= '0;
         timer       <= '0;
         oWrStrobe   <= 1'b0;
         oAddrRam    <= '0;
         oWrDtRam    <= '0;
         oNumOfCoeff <= '0;
         oErr        <= '0;
      end else begin
         oWrStrobe <= 1'b0;
         case (state)
            S_IDLE: begin
               if (iStart) begin
                  if (start_ok) begin
                     n_req <= iNumReq;
                     idx   <= '0;
                     sum   <= '0;
                     timer <= '0;
                     oErr  <= 2'd0;
                  end else begin
                     oErr  <= 2'd1;
                  end
               end
            end
            S_LOAD: begin
               timer <= accept ? '0 : timer + 1'b1;
               if (accept) begin
                  oWrStrobe <= 1'b1;
                  oAddrRam  <= idx;
                  oWrDtRam  <= iCoeffData;
                  idx       <= idx + 1'b1;
                  sum       <= sum + iCoeffData;
               end else if (expired) begin
                  oErr <= 2'd3;
               end
            end
            S_CHECK: begin
               timer <= accept ? '0 : timer + 1'b1;
               if (accept) begin
                  if (iCoeffData == sum) begin
                     oNumOfCoeff <= n_req;
                     oErr        <= 2'd0;
                  end else begin
                     oErr        <= 2'd2;
                  end
               end else if (expired) begin
                  oErr <= 2'd3;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
